// File: rtl/rv32i_alu_pkg.sv
// Shared definitions for the RV32I execute-stage ALU: opcode width and encoding.
package rv32i_alu_pkg;

    localparam int unsigned ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

endpackage

// File: rtl/rv32i_alu_shifter.sv
// Log2(W)-stage barrel shifter. Left shifts reuse the right-shift network by
// bit-reversing the data on the way in and out.
module rv32i_alu_shifter #(
    parameter int unsigned ALU_WIDTH = 32,
    parameter int unsigned SHAMT_W   = $clog2(ALU_WIDTH)
) (
    input  logic [ALU_WIDTH-1:0] data_i,
    input  logic [SHAMT_W-1:0]   shamt_i,
    input  logic                 dir_i,    // 1 = left, 0 = right
    input  logic                 arith_i,  // sign fill on right shifts
    output logic [ALU_WIDTH-1:0] data_o
);

    logic [ALU_WIDTH-1:0] data_rev;
    logic [ALU_WIDTH-1:0] stage [SHAMT_W+1];
    logic [ALU_WIDTH-1:0] out_rev;
    logic                 fill;

    for (genvar i = 0; i < ALU_WIDTH; i++) begin : g_rev_in
        assign data_rev[i] = data_i[ALU_WIDTH-1-i];
    end

    assign fill     = arith_i & ~dir_i & data_i[ALU_WIDTH-1];
    assign stage[0] = dir_i ? data_rev : data_i;

    for (genvar s = 0; s < SHAMT_W; s++) begin : g_stage
        localparam int unsigned Step = 2 ** s;
        assign stage[s+1] = shamt_i[s] ? {{Step{fill}}, stage[s][ALU_WIDTH-1:Step]}
                                       : stage[s];
    end

    for (genvar i = 0; i < ALU_WIDTH; i++) begin : g_rev_out
        assign out_rev[i] = stage[SHAMT_W][ALU_WIDTH-1-i];
    end

    assign data_o = dir_i ? out_rev : stage[SHAMT_W];

endmodule

// File: rtl/rv32i_alu.sv
// RV32I integer ALU: combinational result/zero/illegal_op plus a registered
// copy of result and zero for pipeline forwarding.
module rv32i_alu
    import rv32i_alu_pkg::*;
#(
    parameter int unsigned ALU_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ALU_WIDTH-1:0] op1,
    input  logic [ALU_WIDTH-1:0] op2,
    input  logic [3:0]           alu_op,
    output logic [ALU_WIDTH-1:0] alu_out,
    output logic                 zero,
    output logic [ALU_WIDTH-1:0] alu_out_q,
    output logic                 zero_q,
    output logic                 illegal_op
);

    localparam int unsigned SHAMT_W = $clog2(ALU_WIDTH);

    logic                 is_sub;
    logic [ALU_WIDTH-1:0] b_eff;
    logic [ALU_WIDTH-1:0] sum;
    logic                 carry;
    logic                 overflow;
    logic                 lt_signed;
    logic                 lt_unsigned;
    logic [ALU_WIDTH-1:0] shift_res;
    logic                 shift_left;
    logic                 shift_arith;
    logic [ALU_WIDTH-1:0] alu_out_d;
    logic                 zero_d;

    // SUB, SLT and SLTU all share one adder computing op1 + ~op2 + 1.
    always_comb begin
        is_sub = (alu_op == ALU_SUB) || (alu_op == ALU_SLT) || (alu_op == ALU_SLTU);
        b_eff  = is_sub ? ~op2 : op2;
        {carry, sum} = {1'b0, op1} + {1'b0, b_eff} + {{ALU_WIDTH{1'b0}}, is_sub};
        overflow    = (op1[ALU_WIDTH-1] != op2[ALU_WIDTH-1]) &&
                      (sum[ALU_WIDTH-1] != op1[ALU_WIDTH-1]);
        lt_signed   = sum[ALU_WIDTH-1] ^ overflow;
        lt_unsigned = ~carry;
    end

    assign shift_left  = (alu_op == ALU_SLL);
    assign shift_arith = (alu_op == ALU_SRA);

    rv32i_alu_shifter #(
        .ALU_WIDTH (ALU_WIDTH),
        .SHAMT_W   (SHAMT_W)
    ) u_shifter (
        .data_i  (op1),
        .shamt_i (op2[SHAMT_W-1:0]),
        .dir_i   (shift_left),
        .arith_i (shift_arith),
        .data_o  (shift_res)
    );

    always_comb begin
        alu_out    = '0;
        illegal_op = 1'b0;
        case (alu_op)
            ALU_ADD,
            ALU_SUB:  alu_out = sum;
            ALU_AND:  alu_out = op1 & op2;
            ALU_OR:   alu_out = op1 | op2;
            ALU_XOR:  alu_out = op1 ^ op2;
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:  alu_out = shift_res;
            ALU_SLT:  alu_out = {{(ALU_WIDTH-1){1'b0}}, lt_signed};
            ALU_SLTU: alu_out = {{(ALU_WIDTH-1){1'b0}}, lt_unsigned};
            default:  illegal_op = 1'b1;
        endcase
        zero = (alu_out == '0);
    end

    always_comb begin
        alu_out_d = alu_out;
        zero_d    = zero;
    end

    // Reset value of zero_q is 1 to stay consistent with the cleared result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_out_q <= '0;
            zero_q    <= 1'b1;
        end else begin
            alu_out_q <= alu_out_d;
            zero_q    <= zero_d;
        end
    end

endmodule

// File: tb/tb_rv32i_alu.sv
// Directed self-checking bench for rv32i_alu with hand-computed expectations.
module tb_rv32i_alu;

    logic        clk;
    logic        rst;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  alu_op;
    logic [31:0] alu_out;
    logic        zero;
    logic [31:0] alu_out_q;
    logic        zero_q;
    logic        illegal_op;

    int n_cmp;
    int n_err;

    rv32i_alu #(
        .ALU_WIDTH (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .op1        (op1),
        .op2        (op2),
        .alu_op     (alu_op),
        .alu_out    (alu_out),
        .zero       (zero),
        .alu_out_q  (alu_out_q),
        .zero_q     (zero_q),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one combinational vector and check result, zero and illegal_op.
    task automatic vec(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_out,
                       input logic exp_zero, input logic exp_ill);
        alu_op = op;
        op1    = a;
        op2    = b;
        #1;
        check({tag, ".out"}, alu_out, exp_out);
        check({tag, ".zero"}, {31'd0, zero}, {31'd0, exp_zero});
        check({tag, ".ill"}, {31'd0, illegal_op}, {31'd0, exp_ill});
    endtask

    initial begin
        #20000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        rst    = 1'b1;
        op1    = 32'd0;
        op2    = 32'd0;
        alu_op = 4'd0;
        #2;
        check("reset.out_q", alu_out_q, 32'h0000_0000);
        check("reset.zero_q", {31'd0, zero_q}, 32'd1);
        @(posedge clk);
        #1;
        check("reset_hold.out_q", alu_out_q, 32'h0000_0000);

        vec("add",       4'd0, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 1'b0, 1'b0);
        vec("add_wrap",  4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);
        vec("sub",       4'd1, 32'h0000_0030, 32'h0000_0020, 32'h0000_0010, 1'b0, 1'b0);
        vec("sub_wrap",  4'd1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0);
        vec("and",       4'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0);
        vec("or",        4'd3, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b0, 1'b0);
        vec("xor",       4'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1'b0, 1'b0);
        vec("sll",       4'd5, 32'h0000_0001, 32'h0000_0004, 32'h0000_0010, 1'b0, 1'b0);
        vec("sll_hi",    4'd5, 32'h0000_0001, 32'h0000_0024, 32'h0000_0010, 1'b0, 1'b0);
        vec("sll_31",    4'd5, 32'h0000_0003, 32'h0000_001F, 32'h8000_0000, 1'b0, 1'b0);
        vec("sll_0",     4'd5, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1'b0, 1'b0);
        vec("srl",       4'd6, 32'h0000_0010, 32'h0000_0002, 32'h0000_0004, 1'b0, 1'b0);
        vec("srl_msb",   4'd6, 32'h8000_0000, 32'h0000_0002, 32'h2000_0000, 1'b0, 1'b0);
        vec("srl_31",    4'd6, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0, 1'b0);
        vec("sra",       4'd7, 32'h8000_0000, 32'h0000_0002, 32'hE000_0000, 1'b0, 1'b0);
        vec("sra_31",    4'd7, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 1'b0, 1'b0);
        vec("sra_pos",   4'd7, 32'h4000_0000, 32'h0000_0003, 32'h0800_0000, 1'b0, 1'b0);
        vec("sra_0",     4'd7, 32'h8765_4321, 32'h0000_0000, 32'h8765_4321, 1'b0, 1'b0);
        vec("slt",       4'd8, 32'h0000_0010, 32'h0000_0020, 32'h0000_0001, 1'b0, 1'b0);
        vec("slt_neg",   4'd8, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
        vec("slt_eq",    4'd8, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0);
        vec("slt_ovf",   4'd8, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        vec("slt_ovf2",  4'd8, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0);
        vec("sltu_big",  4'd9, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);
        vec("sltu_ovf",  4'd9, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        vec("sltu_lt",   4'd9, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        vec("ill_12",    4'd12, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1);
        vec("ill_10",    4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1);
        vec("ill_15",    4'd15, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1);

        // Registered path: release reset, then capture ADD 3+4.
        @(negedge clk);
        rst = 1'b0;
        vec("reg_add", 4'd0, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 1'b0, 1'b0);
        check("reg_pre.out_q", alu_out_q, 32'h0000_0000);
        @(posedge clk);
        #1;
        check("reg_lat.out_q", alu_out_q, 32'h0000_0007);
        check("reg_lat.zero_q", {31'd0, zero_q}, 32'd0);

        // Mid-cycle reset clears the registers without a clock edge.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_async.out_q", alu_out_q, 32'h0000_0000);
        check("rst_async.zero_q", {31'd0, zero_q}, 32'd1);
        check("rst_comb.out", alu_out, 32'h0000_0007);

        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_rel.out_q", alu_out_q, 32'h0000_0000);
        @(posedge clk);
        #1;
        check("rst_rel_edge.out_q", alu_out_q, 32'h0000_0007);
        check("rst_rel_edge.zero_q", {31'd0, zero_q}, 32'd0);

        // A zero result registers with zero_q set.
        @(negedge clk);
        vec("reg_wrap", 4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check("reg_wrap.out_q", alu_out_q, 32'h0000_0000);
        check("reg_wrap.zero_q", {31'd0, zero_q}, 32'd1);

        // Next-edge follow-up: registered value tracks a new input.
        @(negedge clk);
        vec("reg_xor", 4'd4, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5, 1'b0, 1'b0);
        check("reg_xor_pre.out_q", alu_out_q, 32'h0000_0000);
        @(posedge clk);
        #1;
        check("reg_xor.out_q", alu_out_q, 32'h5A5A_A5A5);
        check("reg_xor.zero_q", {31'd0, zero_q}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rv32i_alu.md
Name: rv32i_alu

Overview:
- RV32I integer ALU for the execute stage. Computes ADD/SUB/AND/OR/XOR/SLL/SRL/SRA/SLT/SLTU from two operands and a 4-bit operation code.
- Result and zero flag are combinational, so they are valid in the same cycle.
- A registered copy of the result and flags is also provided for pipeline or forwarding use. It is clocked by the single core clock and has an asynchronous active-high reset.

Parameters:
- ALU_WIDTH, 32, operand/result width in bits. Must be a power of two, ≥ 8.
- SHAMT_W, $clog2(ALU_WIDTH), derived local parameter: shift-amount width (5 for 32).

Ports:
- clk  input  1  core clock; rising edge updates registered outputs
- rst  input  1  asynchronous, active-high reset for registered outputs
- op1  input  ALU_WIDTH  operand A (rs1 / PC)
- op2  input  ALU_WIDTH  operand B (rs2 / immediate)
- alu_op  input  4  operation select (encoding below)
- alu_out  output  ALU_WIDTH  combinational result
- zero  output  1  combinational: 1 when alu_out == 0
- alu_out_q  output  ALU_WIDTH  alu_out registered on clk
- zero_q  output  1  zero registered on clk
- illegal_op  output  1  combinational: 1 when alu_op ≥ 10

Behaviour:
- Opcode encoding:
  - 0 ADD: op1+op2, modulo 2^W, carry discarded
  - 1 SUB: op1−op2, modulo 2^W
  - 2 AND, 3 OR, 4 XOR: bitwise
  - 5 SLL: op1 << op2[SHAMT_W-1:0]
  - 6 SRL: logical right shift by op2[SHAMT_W-1:0], zero fill
  - 7 SRA: arithmetic right shift by op2[SHAMT_W-1:0], sign fill from op1[W-1]
  - 8 SLT: 1 if signed(op1) < signed(op2), else 0; result zero-extended to W
  - 9 SLTU: 1 if unsigned(op1) < unsigned(op2), else 0; zero-extended
  - 10–15: alu_out = 0, illegal_op = 1
- Shift amount: only the low SHAMT_W bits of op2 are used; upper bits are ignored (op2=32'h24 shifts by 4).
- Combinational path:
  - alu_out, zero and illegal_op settle within the same delta/cycle as any input change.
  - No latches; every output is assigned on every path.
- Registered path:
  - alu_out_q and zero_q capture alu_out and zero on each rising clk. Latency is 1 cycle; there is no enable.
- Reset:
  - rst=1 forces alu_out_q=0 and zero_q=1 immediately, independent of clk. The value 1 is consistent with a zero result.
  - On deassertion, the registered outputs update on the next rising clk.
  - Combinational outputs are unaffected by rst.
- Boundary conditions:
  - ADD overflow wraps silently, e.g. FFFFFFFF+1 = 0 with zero=1.
  - SUB underflow wraps.
  - Shift by 0 returns op1.
  - Shift by W−1 is the maximum.
  - SLT of equal operands returns 0.
  - SLT(80000000, 7FFFFFFF) = 1; SLTU of the same pair = 0.

Decomposition:
- Shared package rv32i_alu_pkg:
  - enum alu_op_e (4-bit) with ALU_ADD=0 … ALU_SLTU=9
  - constant ALU_OP_W=4
  - The decoder and this block both import it.
- One natural sub-module: rv32i_alu_shifter, a parameterised barrel shifter (ALU_WIDTH, SHAMT_W).
  - Inputs: data, shamt, dir (left/right), arith.
  - Output: shifted data.
  - Implemented as log2(W) mux stages.
- Adder/subtractor and comparators stay in the top level:
  - SUB is computed as op1 + ~op2 + 1.
  - SLT/SLTU are derived from that subtraction's carry, overflow and sign.

Test Plan:
- ADD 00000010+00000020 -> alu_out=00000030, zero=0.
- ADD FFFFFFFF+00000001 -> 00000000, zero=1.
- SUB 00000030−00000020 -> 00000010.
- SUB 0−1 -> FFFFFFFF.
- Bitwise on F0F0F0F0, 0FF00FF0 -> AND 00F000F0, OR FFF0FFF0, XOR FF00FF00.
- SLL 1 by 4 -> 00000010.
- SRL 00000010 by 2 -> 00000004.
- SRA 80000000 by 2 -> E0000000.
- SRL 80000000 by 2 -> 20000000.
- op2 = 00000024 for SLL of 1 -> 00000010 (upper shamt bits ignored).
- Compares:
  - SLT 10 vs 20 -> 1.
  - SLTU FFFFFFFF vs 1 -> 0.
  - SLT FFFFFFFF vs 1 -> 1.
  - SLT 5 vs 5 -> 0.
  - alu_op=12 -> alu_out=0, illegal_op=1.
- Registered path:
  - Assert rst mid-cycle -> alu_out_q=0 and zero_q=1 immediately.
  - Release rst, apply ADD 3+4 -> alu_out_q=00000007 one rising edge later, zero_q=0.
